// File: rtl/axil_txn_arbiter.sv
// Two-requester round-robin sequencer for single-beat AXI4-Lite transactions
// on one shared master port; at most one transaction in flight.
module axil_txn_arbiter #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [1:0]              REQ_VALID,
    input  logic [1:0]              REQ_WRITE,
    input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
    input  logic [7:0]              REQ_WSTRB,
    output logic [1:0]              REQ_READY,
    output logic [1:0]              REQ_DONE,
    output logic [DATA_WIDTH-1:0]   REQ_RDATA,
    output logic [1:0]              REQ_RESP,
    output logic                    BUSY,
    output logic                    ERROR,
    input  logic                    ERR_CLR,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_W_ADDR_DATA = 3'd1,
        S_W_RESP      = 3'd2,
        S_R_ADDR      = 3'd3,
        S_R_DATA      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [1:0]              req_done_q, req_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    error_q, error_d;
    logic                    err_set_s;
    logic                    win_valid_s;
    logic                    win_idx_s;
    logic [1:0]              req_ready_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [DATA_WIDTH-1:0]   win_wdata_s;
    logic [3:0]              win_wstrb_s;

    // Round-robin winner: on contention the requester that did not win last time goes
    always_comb begin
        win_valid_s = |REQ_VALID;
        case (REQ_VALID)
            2'b01:   win_idx_s = 1'b0;
            2'b10:   win_idx_s = 1'b1;
            2'b11:   win_idx_s = ~last_grant_q;
            default: win_idx_s = 1'b0;
        endcase
    end

    assign win_addr_s  = win_idx_s ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
    assign win_wdata_s = win_idx_s ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
    assign win_wstrb_s = win_idx_s ? REQ_WSTRB[7:4] : REQ_WSTRB[3:0];

    // Next-state, capture and completion logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        req_done_d   = 2'b00;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        err_set_s    = 1'b0;
        req_ready_s  = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (win_valid_s) begin
                    req_ready_s[win_idx_s] = 1'b1;
                    grant_d      = win_idx_s;
                    last_grant_d = win_idx_s;
                    addr_d       = win_addr_s;
                    wdata_d      = win_wdata_s;
                    wstrb_d      = win_wstrb_s;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = REQ_WRITE[win_idx_s] ? S_W_ADDR_DATA : S_R_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_W_ADDR_DATA: begin
                // AW and W complete independently; the flags remember which already did
                aw_done_d = aw_done_q | M_AXI_AWREADY;
                w_done_d  = w_done_q | M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    state_d = S_W_RESP;
                end else begin
                    state_d = S_W_ADDR_DATA;
                end
            end
            S_W_RESP: begin
                if (M_AXI_BVALID) begin
                    req_done_d[grant_q] = 1'b1;
                    resp_d    = M_AXI_BRESP;
                    err_set_s = (M_AXI_BRESP != 2'b00);
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_W_RESP;
                end
            end
            S_R_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_R_DATA;
                end else begin
                    state_d = S_R_ADDR;
                end
            end
            S_R_DATA: begin
                if (M_AXI_RVALID) begin
                    req_done_d[grant_q] = 1'b1;
                    rdata_d   = M_AXI_RDATA;
                    resp_d    = M_AXI_RRESP;
                    err_set_s = (M_AXI_RRESP != 2'b00);
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_R_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A new error outranks a simultaneous clear
        error_d = err_set_s | (error_q & ~ERR_CLR);
    end

    // State and datapath registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= 4'h0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            req_done_q   <= 2'b00;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            req_done_q   <= req_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            error_q      <= error_d;
        end
    end

    assign REQ_READY     = req_ready_s;
    assign REQ_DONE      = req_done_q;
    assign REQ_RDATA     = rdata_q;
    assign REQ_RESP      = resp_q;
    assign BUSY          = (state_q != S_IDLE);
    assign ERROR         = error_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_AWVALID = (state_q == S_W_ADDR_DATA) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = (state_q == S_W_ADDR_DATA) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_W_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_ARVALID = (state_q == S_R_ADDR);
    assign M_AXI_RREADY  = (state_q == S_R_DATA);

endmodule
